// File: rtl/hazard_stall_unit_if.sv
// ============================================================================
// Module      : hazard_stall_unit_if
// Description : ID/EX hazard inputs and pipeline hold/flush controls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_stall_unit_if #(
  parameter int CNT_W = 16
);
  logic [1:0]       if_id_ra;
  logic [1:0]       if_id_rb;
  logic             if_id_uses_ra;
  logic             if_id_uses_rb;
  logic             id_ex_mem_read;
  logic [1:0]       id_ex_reg_dest;
  logic             branch_taken;
  logic             mem_busy;
  logic             pc_write_en;
  logic             if_id_write_en;
  logic             id_ex_write_en;
  logic             ex_mem_write_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic [1:0]       hazard_state;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output if_id_ra, if_id_rb, if_id_uses_ra, if_id_uses_rb,
           id_ex_mem_read, id_ex_reg_dest, branch_taken, mem_busy,
    input  pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en,
           if_id_flush, id_ex_flush, hazard_state, stall_count
  );

  modport slave (
    input  if_id_ra, if_id_rb, if_id_uses_ra, if_id_uses_rb,
           id_ex_mem_read, id_ex_reg_dest, branch_taken, mem_busy,
    output pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en,
           if_id_flush, id_ex_flush, hazard_state, stall_count
  );
endinterface

`default_nettype wire

// File: rtl/hazard_stall_unit.sv
// ============================================================================
// Module      : hazard_stall_unit
// Description : Load-use stall, branch flush and memory-wait freeze control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_stall_unit #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_stall_unit_if.slave hz
);

  localparam logic [1:0] c_ST_RUN        = 2'b00;
  localparam logic [1:0] c_ST_LOAD_STALL = 2'b01;
  localparam logic [1:0] c_ST_FREEZE     = 2'b10;
  localparam logic [2:0] c_REM_INIT      = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [2:0]       r_remaining;
  logic [CNT_W-1:0] r_stall_count;

  logic [1:0] w_next_state;
  logic [2:0] w_next_remaining;
  logic       w_load_use;
  logic       w_stall_event;
  logic       w_pc_we;
  logic       w_if_id_we;
  logic       w_id_ex_we;
  logic       w_ex_mem_we;
  logic       w_if_id_flush;
  logic       w_id_ex_flush;

  assign w_load_use = hz.id_ex_mem_read &
                      ((hz.if_id_uses_ra & (hz.if_id_ra == hz.id_ex_reg_dest)) |
                       (hz.if_id_uses_rb & (hz.if_id_rb == hz.id_ex_reg_dest)));

  always_comb begin
    w_pc_we          = 1'b1;
    w_if_id_we       = 1'b1;
    w_id_ex_we       = 1'b1;
    w_ex_mem_we      = 1'b1;
    w_if_id_flush    = 1'b0;
    w_id_ex_flush    = 1'b0;
    w_next_state     = r_state;
    w_next_remaining = r_remaining;

    if (!rst_n) begin
      w_pc_we          = 1'b0;
      w_if_id_we       = 1'b0;
      w_id_ex_we       = 1'b0;
      w_ex_mem_we      = 1'b0;
      w_if_id_flush    = 1'b1;
      w_id_ex_flush    = 1'b1;
      w_next_state     = c_ST_RUN;
      w_next_remaining = 3'd0;
    end else if (hz.mem_busy) begin
      // Freeze everything; state and remaining bubbles are preserved
      w_pc_we     = 1'b0;
      w_if_id_we  = 1'b0;
      w_id_ex_we  = 1'b0;
      w_ex_mem_we = 1'b0;
    end else if (hz.branch_taken) begin
      w_if_id_flush    = 1'b1;
      w_id_ex_flush    = 1'b1;
      w_next_state     = c_ST_RUN;
      w_next_remaining = 3'd0;
    end else if ((r_state == c_ST_LOAD_STALL) || w_load_use) begin
      // Hold PC and IF/ID, inject a bubble into ID/EX
      w_pc_we       = 1'b0;
      w_if_id_we    = 1'b0;
      w_id_ex_flush = 1'b1;
      if (r_state == c_ST_LOAD_STALL) begin
        w_next_remaining = r_remaining - 3'd1;
        w_next_state     = (r_remaining == 3'd1) ? c_ST_RUN : c_ST_LOAD_STALL;
      end else if (LOAD_STALL_CYCLES > 1) begin
        w_next_state     = c_ST_LOAD_STALL;
        w_next_remaining = c_REM_INIT;
      end
    end
  end

  assign w_stall_event = rst_n & (~w_pc_we | w_if_id_flush | w_id_ex_flush);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= c_ST_RUN;
      r_remaining   <= 3'd0;
      r_stall_count <= '0;
    end else begin
      r_state     <= w_next_state;
      r_remaining <= w_next_remaining;
      if (w_stall_event && (r_stall_count != {CNT_W{1'b1}})) begin
        r_stall_count <= r_stall_count + c_CNT_ONE;
      end
    end
  end

  assign hz.pc_write_en     = w_pc_we;
  assign hz.if_id_write_en  = w_if_id_we;
  assign hz.id_ex_write_en  = w_id_ex_we;
  assign hz.ex_mem_write_en = w_ex_mem_we;
  assign hz.if_id_flush     = w_if_id_flush;
  assign hz.id_ex_flush     = w_id_ex_flush;
  assign hz.hazard_state    = (rst_n && hz.mem_busy) ? c_ST_FREEZE : r_state;
  assign hz.stall_count     = r_stall_count;

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
// ============================================================================
// Module      : tb_hazard_stall_unit
// Description : Directed and random checks of two configurations (LSC=1, LSC=3).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_stall_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_stall_unit_if #(.CNT_W(16)) bus1 ();
  hazard_stall_unit_if #(.CNT_W(4))  bus3 ();

  hazard_stall_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .hz(bus1)
  );
  hazard_stall_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .hz(bus3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: count of pending extra bubbles and stall counter per config
  int m_pending [2] = '{0, 0};
  int m_count   [2] = '{0, 0};
  int c_lsc     [2] = '{1, 3};
  int c_max     [2] = '{65535, 15};

  logic [1:0] s_ra, s_rb, s_dest;
  logic       s_ura, s_urb, s_mr, s_br, s_mb, s_rn;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] ra, input logic [1:0] rb, input logic ura,
                       input logic urb, input logic mr, input logic [1:0] dest,
                       input logic br, input logic mb, input logic rn);
    s_ra = ra; s_rb = rb; s_ura = ura; s_urb = urb; s_mr = mr;
    s_dest = dest; s_br = br; s_mb = mb; s_rn = rn;
    bus1.if_id_ra = ra;  bus3.if_id_ra = ra;
    bus1.if_id_rb = rb;  bus3.if_id_rb = rb;
    bus1.if_id_uses_ra = ura; bus3.if_id_uses_ra = ura;
    bus1.if_id_uses_rb = urb; bus3.if_id_uses_rb = urb;
    bus1.id_ex_mem_read = mr; bus3.id_ex_mem_read = mr;
    bus1.id_ex_reg_dest = dest; bus3.id_ex_reg_dest = dest;
    bus1.branch_taken = br; bus3.branch_taken = br;
    bus1.mem_busy = mb; bus3.mem_busy = mb;
    rst_n = rn;
  endtask

  task automatic step(input string tag);
    logic [7:0]  exp_ctl, obs_ctl;
    logic [31:0] obs_cnt;
    logic        lu, ev;
    @(negedge clk);
    lu = s_mr && ((s_ura && s_ra == s_dest) || (s_urb && s_rb == s_dest));
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        obs_ctl = {bus1.pc_write_en, bus1.if_id_write_en, bus1.id_ex_write_en,
                   bus1.ex_mem_write_en, bus1.if_id_flush, bus1.id_ex_flush, bus1.hazard_state};
        obs_cnt = 32'(bus1.stall_count);
      end else begin
        obs_ctl = {bus3.pc_write_en, bus3.if_id_write_en, bus3.id_ex_write_en,
                   bus3.ex_mem_write_en, bus3.if_id_flush, bus3.id_ex_flush, bus3.hazard_state};
        obs_cnt = 32'(bus3.stall_count);
      end
      if (!s_rn) begin
        exp_ctl = 8'b0000_11_00;
        m_pending[k] = 0;
        m_count[k]   = 0;
      end else if (s_mb) begin
        exp_ctl = 8'b0000_00_10;
      end else if (s_br) begin
        exp_ctl = {6'b1111_11, (m_pending[k] > 0) ? 2'b01 : 2'b00};
        m_pending[k] = 0;
      end else if (m_pending[k] > 0) begin
        exp_ctl = 8'b0011_01_01;
        m_pending[k]--;
      end else if (lu) begin
        exp_ctl = 8'b0011_01_00;
        m_pending[k] = c_lsc[k] - 1;
      end else begin
        exp_ctl = 8'b1111_00_00;
      end
      check_eq({tag, (k == 0) ? "_ctl_lsc1" : "_ctl_lsc3"}, 32'(obs_ctl), 32'(exp_ctl));
      check_eq({tag, (k == 0) ? "_cnt_lsc1" : "_cnt_lsc3"}, obs_cnt, 32'(m_count[k]));
      ev = s_rn && (!exp_ctl[7] || exp_ctl[3] || exp_ctl[2]);
      if (ev && m_count[k] < c_max[k]) m_count[k]++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
      step("idle");
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      drive(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      step("reset");
    end
  endtask

  initial begin
    do_reset(2);

    // Load to r2 in EX while ID reads r2 via ra
    drive(2'd2, 2'd0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
    step("load_use");
    idle(4);
    check_eq("lu_total_lsc1", 32'(bus1.stall_count), 32'd1);
    check_eq("lu_total_lsc3", 32'(bus3.stall_count), 32'd3);

    // rb matches but is unused; then a non-load writing the read register
    drive(2'd0, 2'd1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
    step("unused_rb");
    drive(2'd1, 2'd0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1);
    step("non_load");
    idle(2);
    check_eq("nostall_lsc1", 32'(bus1.stall_count), 32'd1);
    check_eq("nostall_lsc3", 32'(bus3.stall_count), 32'd3);

    // Branch taken together with a load-use hazard
    do_reset(1);
    drive(2'd2, 2'd0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1);
    step("branch_lu");
    idle(3);
    check_eq("branch_lsc1", 32'(bus1.stall_count), 32'd1);
    check_eq("branch_lsc3", 32'(bus3.stall_count), 32'd1);

    // Memory wait for 4 cycles in the middle of a load stall
    do_reset(1);
    drive(2'd2, 2'd0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
    step("lu_pre_busy");
    for (int i = 0; i < 4; i++) begin
      drive(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
      step("mem_busy");
    end
    idle(4);
    check_eq("busy_lsc1", 32'(bus1.stall_count), 32'd5);
    check_eq("busy_lsc3", 32'(bus3.stall_count), 32'd7);

    // Reset arriving after the first bubble of a 3-cycle stall
    do_reset(1);
    drive(2'd2, 2'd0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
    step("lu_pre_reset");
    do_reset(1);
    check_eq("midreset_state", 32'(bus3.hazard_state), 32'd0);
    idle(3);
    check_eq("midreset_cnt", 32'(bus3.stall_count), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      logic rn, mb;
      rn = ($urandom_range(0, 99) != 0);
      mb = rn && ($urandom_range(0, 99) < 15);
      drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 99) < 10), mb, rn);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
